i2s_dac_transmitter: RTL

Output-side counterpart of the sample-processing path. It accepts 16-bit processed samples over a valid/ready handshake and buffers them in a small FIFO. It serializes them onto the codec DAC data line in I2S format, slaved to the codec-generated BCLK and LRCK. Both codec clocks are oversampled in the `sample_clock` domain, which must run at ≥8× BCLK.

---
 rtl/i2s_dac_transmitter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/i2s_dac_transmitter.sv
// I2S DAC transmitter: valid/ready sample FIFO serialized onto dacdat, slaved to codec bclk/lrck.
// Optional build macro SAMPLE_DUP_EN: each FIFO entry is sent in both left and right slots.
module i2s_dac_transmitter #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sample_clock,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             in_sample,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          bclk,
    input  logic                          lrck,
    output logic                          dacdat,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DATA_W + 1);

    localparam logic [2:0] ST_ALIGN = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT1 = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_PAD   = 3'd4;

    logic [1:0]        bclk_sync, lrck_sync;
    logic              bclk_prev, lrck_smp, lrck_seen;
    logic              fall_ev, lrck_edge;
    logic [2:0]        state;
    logic              slot_right;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              push, pop, fifo_empty, load_wants_pop;
    logic [LW-1:0]     level_next;
    logic [DATA_W-1:0] fifo_head, load_word;

    // The first fall event after reset only seeds the LRCK reference, so a
    // mid-frame reset release never counts as a slot boundary.
    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            bclk_sync <= '0;
            lrck_sync <= '0;
            bclk_prev <= 1'b0;
            lrck_smp  <= 1'b0;
            lrck_seen <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[0], bclk};
            lrck_sync <= {lrck_sync[0], lrck};
            bclk_prev <= bclk_sync[1];
            if (fall_ev) begin
                lrck_smp  <= lrck_sync[1];
                lrck_seen <= 1'b1;
            end
        end
    end

    assign fall_ev   = bclk_prev & ~bclk_sync[1];
    assign lrck_edge = fall_ev & lrck_seen & (lrck_sync[1] != lrck_smp);

    assign fifo_empty = (fifo_level == '0);
    assign fifo_head  = fifo_empty ? '0 : mem[rd_ptr];
    assign push       = in_valid & in_ready;

`ifdef SAMPLE_DUP_EN
    logic [DATA_W-1:0] held;

    // Right slot replays the word the left slot took from the FIFO.
    assign load_wants_pop = (state == ST_LOAD) & ~slot_right;
    assign load_word      = slot_right ? held : fifo_head;

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset)
            held <= '0;
        else if (load_wants_pop)
            held <= fifo_head;
    end
`else
    assign load_wants_pop = (state == ST_LOAD);
    assign load_word      = fifo_head;
`endif

    assign pop        = load_wants_pop & ~fifo_empty;
    assign level_next = fifo_level + LW'(push) - LW'(pop);

    always_ff @(posedge sample_clock) begin
        if (push)
            mem[wr_ptr] <= in_sample;
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            in_ready   <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= level_next;
            in_ready   <= (level_next != LW'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_ALIGN;
            slot_right <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            dacdat     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (lrck_edge)
                slot_right <= lrck_sync[1];
            case (state)
                ST_ALIGN: begin
                    dacdat <= 1'b0;
                    if (lrck_edge) state <= ST_LOAD;
                end
                ST_LOAD: begin
                    shreg    <= load_word;
                    bit_cnt  <= '0;
                    underrun <= load_wants_pop & fifo_empty;
                    state    <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    if (fall_ev) begin
                        if (lrck_edge) begin
                            dacdat <= 1'b0;
                            state  <= ST_LOAD;
                        end else begin
                            dacdat  <= shreg[DATA_W-1];
                            shreg   <= shreg << 1;
                            bit_cnt <= CW'(1);
                            state   <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // A boundary fall still drives the pending bit: with a
                    // DATA_W-bit slot that is the LSB, as I2S expects.
                    if (fall_ev) begin
                        if (bit_cnt == CW'(DATA_W)) begin
                            dacdat <= 1'b0;
                        end else begin
                            dacdat  <= shreg[DATA_W-1];
                            shreg   <= shreg << 1;
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (lrck_edge)
                            state <= ST_LOAD;
                        else if (bit_cnt == CW'(DATA_W))
                            state <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    dacdat <= 1'b0;
                    if (lrck_edge) state <= ST_LOAD;
                end
                default: state <= ST_ALIGN;
            endcase
        end
    end

endmodule
